fpu_trig_range_reducer: RTL and testbench

//  Argument reduction stage in front of the FSIN/FCOS/FPTAN microcode (programs 5/6).

---
 rtl/fpu_trig_range_reducer.sv | 214 +++++++++++++++++++++
 tb/tb_fpu_trig_range_reducer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_trig_range_reducer.sv
// Trig argument reduction: r = x - q*(pi/2) with |r| <= pi/4 and q mod 4.
// It produces one quotient bit per clock from a shift-subtract remainder against pi/2.
module fpu_trig_range_reducer #(
    parameter int          FRAC_BITS = 64,
    parameter logic [65:0] PIO2      = 66'h1_921F_B544_42D1_846A,
    parameter int          MAX_EXP   = 62
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [79:0] operand_in,
    output logic        ready,
    output logic        done,
    output logic [79:0] result_out,
    output logic [1:0]  quadrant,
    output logic        invalid,
    output logic        out_of_range
);

    localparam int          CNT_W         = $clog2(MAX_EXP + 66);
    localparam logic [14:0] EXP_BIAS      = 15'd16383;
    localparam logic [14:0] EXP_BYPASS    = 15'd16382;
    localparam logic [14:0] EXP_MAX_B     = 15'(16383 + MAX_EXP);
    localparam logic [14:0] EXP_NORM_BASE = 15'(16383 - FRAC_BITS);
    localparam logic [14:0] CNT_OFFSET    = 15'(16383 - 65);
    localparam logic [65:0] PIO4          = PIO2 >> 1;
    localparam logic [79:0] INDEFINITE    = 80'hFFFF_C000_0000_0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_DIVIDE,
        S_ADJUST,
        S_NORMALIZE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [79:0]        x_q, x_d;
    logic [65:0]        rem_q, rem_d;
    logic [1:0]         quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        bits_q, bits_d;
    logic [63:0]        mag_q, mag_d;
    logic               neg_q, neg_d;
    logic [79:0]        result_q, result_d;
    logic [1:0]         quadrant_q, quadrant_d;
    logic               invalid_q, invalid_d;
    logic               oor_q, oor_d;

    logic               x_sign;
    logic [14:0]        x_exp;
    logic [63:0]        x_mant;
    logic [65:0]        trial;
    logic               trial_ge;
    logic [5:0]         lod_pos;
    logic               lod_hit;

    assign x_sign = x_q[79];
    assign x_exp  = x_q[78:64];
    assign x_mant = x_q[63:0];

    // rem_q[65] is always zero; folding it into the compare keeps the full register observable.
    assign trial    = {rem_q[64:0], bits_q[63]};
    assign trial_ge = rem_q[65] | (trial >= PIO2);

    always_comb begin
        lod_pos = 6'd0;
        lod_hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mag_q[i]) begin
                lod_pos = i[5:0];
                lod_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            bits_q     <= '0;
            mag_q      <= '0;
            neg_q      <= 1'b0;
            result_q   <= '0;
            quadrant_q <= '0;
            invalid_q  <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            bits_q     <= bits_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            result_q   <= result_d;
            quadrant_q <= quadrant_d;
            invalid_q  <= invalid_d;
            oor_q      <= oor_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        bits_d     = bits_q;
        mag_d      = mag_q;
        neg_d      = neg_q;
        result_d   = result_q;
        quadrant_d = quadrant_q;
        invalid_d  = invalid_q;
        oor_d      = oor_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = operand_in;
                    state_d = S_CLASSIFY;
                end
            end

            S_CLASSIFY: begin
                invalid_d = 1'b0;
                oor_d     = 1'b0;
                if (x_exp == 15'h7FFF || (x_exp != 15'd0 && !x_mant[63])) begin
                    invalid_d  = 1'b1;
                    result_d   = INDEFINITE;
                    quadrant_d = 2'd0;
                    state_d    = S_DONE;
                end else if (x_exp < EXP_BYPASS) begin
                    // Zero, denormal or |x| < 0.5: already inside [-pi/4, pi/4].
                    result_d   = x_q;
                    quadrant_d = 2'd0;
                    state_d    = S_DONE;
                end else if (x_exp > EXP_MAX_B) begin
                    oor_d      = 1'b1;
                    result_d   = x_q;
                    quadrant_d = 2'd0;
                    state_d    = S_DONE;
                end else begin
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CNT_W'(x_exp - CNT_OFFSET);
                    bits_d  = x_mant;
                    state_d = S_DIVIDE;
                end
            end

            S_DIVIDE: begin
                if (trial_ge) begin
                    rem_d = trial - PIO2;
                    quo_d = {quo_q[0], 1'b1};
                end else begin
                    rem_d = trial;
                    quo_d = {quo_q[0], 1'b0};
                end
                bits_d = {bits_q[62:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ADJUST;
                end
            end

            S_ADJUST: begin
                // Remainder above pi/4 folds to the next quadrant with a negative residue.
                if (rem_q > PIO4) begin
                    mag_d = 64'(PIO2 - rem_q);
                    neg_d = 1'b1;
                    quo_d = quo_q + 2'd1;
                end else begin
                    mag_d = 64'(rem_q);
                    neg_d = 1'b0;
                end
                state_d = S_NORMALIZE;
            end

            S_NORMALIZE: begin
                if (lod_hit) begin
                    result_d = {x_sign ^ neg_q,
                                EXP_NORM_BASE + {9'd0, lod_pos},
                                mag_q << (6'd63 - lod_pos)};
                end else begin
                    result_d = {x_sign, 79'd0};
                end
                quadrant_d = x_sign ? (2'd0 - quo_q) : quo_q;
                state_d    = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready        = (state_q == S_IDLE);
    assign done         = (state_q == S_DONE);
    assign result_out   = result_q;
    assign quadrant     = quadrant_q;
    assign invalid      = invalid_q;
    assign out_of_range = oor_q;

endmodule

// File: tb/tb_fpu_trig_range_reducer.sv
// Directed and random bench for fpu_trig_range_reducer; expected results are queued
// from a reference model using exact integer division and checked when done pulses.
module tb_fpu_trig_range_reducer;

    localparam logic [65:0] PIO2 = 66'h1_921F_B544_42D1_846A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [79:0] operand_in;
    logic        ready;
    logic        done;
    logic [79:0] result_out;
    logic [1:0]  quadrant;
    logic        invalid;
    logic        out_of_range;

    always #5 clk = ~clk;

    fpu_trig_range_reducer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .operand_in   (operand_in),
        .ready        (ready),
        .done         (done),
        .result_out   (result_out),
        .quadrant     (quadrant),
        .invalid      (invalid),
        .out_of_range (out_of_range)
    );

    typedef struct packed {
        logic [79:0] r;
        logic [1:0]  q;
        logic        inv;
        logic        oor;
        logic [31:0] lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [79:0] last_r;
    logic [1:0]  last_q;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    // Reference: remainder and quotient from one wide divide of x*2^64 by pi/2*2^64.
    function automatic exp_t model(input logic [79:0] x);
        exp_t        o;
        logic        s;
        logic [14:0] ex;
        logic [63:0] m;
        int          e;
        int          p;
        logic [127:0] dvd;
        logic [127:0] qf;
        logic [127:0] rr;
        logic [65:0] rem;
        logic [63:0] mag;
        logic        neg;
        logic [1:0]  qq;
        s  = x[79];
        ex = x[78:64];
        m  = x[63:0];
        e  = int'(ex) - 16383;
        o  = '0;
        o.lat = 32'd1;
        if (ex == 15'h7FFF || (ex != 15'd0 && !m[63])) begin
            o.inv = 1'b1;
            o.r   = 80'hFFFF_C000_0000_0000_0000;
        end else if (ex == 15'd0 || e < -1) begin
            o.r = x;
        end else if (e > 62) begin
            o.oor = 1'b1;
            o.r   = x;
        end else begin
            dvd = 128'(m) << (e + 1);
            qf  = dvd / 128'(PIO2);
            rr  = dvd % 128'(PIO2);
            rem = rr[65:0];
            qq  = qf[1:0];
            if (rem > (PIO2 >> 1)) begin
                mag = 64'(PIO2 - rem);
                neg = 1'b1;
                qq  = qq + 2'd1;
            end else begin
                mag = rem[63:0];
                neg = 1'b0;
            end
            if (mag == 64'd0) begin
                o.r = {s, 79'd0};
            end else begin
                p = 0;
                for (int i = 0; i < 64; i++) if (mag[i]) p = i;
                o.r = {s ^ neg, 15'(16319 + p), mag << (63 - p)};
            end
            o.q   = s ? (2'd0 - qq) : qq;
            o.lat = 32'(e + 68);
        end
        return o;
    endfunction

    task automatic do_op(input string tag, input logic [79:0] x, input int glitch_at);
        exp_t ex;
        int   cyc;
        logic seen;
        chk({tag, " ready"}, 80'(ready), 80'd1);
        @(negedge clk);
        operand_in = x;
        start      = 1'b1;
        sb.push_back(model(x));
        @(posedge clk);
        #1;
        start      = 1'b0;
        operand_in = ~x;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            seen = done;
            if (glitch_at != 0 && cyc == glitch_at) begin
                start      = 1'b1;
                operand_in = 80'h4000_8000_0000_0000_0000;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        ex = sb.pop_front();
        chk({tag, " done seen"}, 80'(seen), 80'd1);
        if (seen) begin
            chk({tag, " result"},   result_out,        ex.r);
            chk({tag, " quadrant"}, 80'(quadrant),     80'(ex.q));
            chk({tag, " invalid"},  80'(invalid),      80'(ex.inv));
            chk({tag, " oor"},      80'(out_of_range), 80'(ex.oor));
            chk({tag, " latency"},  80'(cyc),          80'(ex.lat));
            last_r = result_out;
            last_q = quadrant;
            @(posedge clk);
            #1;
            chk({tag, " done/ready after"}, 80'({done, ready}), 80'b01);
        end
        $display("op %-12s x=%h r=%h q=%0d inv=%0d oor=%0d cycles=%0d",
                 tag, x, result_out, quadrant, invalid, out_of_range, cyc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ready"},    80'(ready),        80'd1);
        chk({tag, " done"},     80'(done),         80'd0);
        chk({tag, " result"},   result_out,        80'd0);
        chk({tag, " quadrant"}, 80'(quadrant),     80'd0);
        chk({tag, " invalid"},  80'(invalid),      80'd0);
        chk({tag, " oor"},      80'(out_of_range), 80'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [79:0] x;
        logic [63:0] rnd;
        logic        seen;
        reset_n    = 1'b0;
        start      = 1'b0;
        operand_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        x = 80'h3FFE_860A_91C1_6B9B_3000;
        do_op("pi/6", x, 0);
        chk("pi/6 r==x", last_r, x);

        do_op("3.0", 80'h4000_C000_0000_0000_0000, 0);
        chk("3.0 q", 80'(last_q), 80'd2);
        chk("3.0 sign", 80'(last_r[79]), 80'd1);
        chk("3.0 exp", 80'(last_r[78:64]), 80'h3FFC);
        chk("3.0 mant", 80'(last_r[63:16]), 80'h90FD_AA22_168C);

        do_op("-pi", 80'hC000_C90F_DAA2_2168_C000, 0);
        chk("-pi q", 80'(last_q), 80'd2);
        chk("-pi tiny", 80'(last_r[78:64] <= 15'd16330), 80'd1);
        do_op("pi/2", 80'h3FFF_C90F_DAA2_2168_C000, 0);
        chk("pi/2 q", 80'(last_q), 80'd1);
        chk("pi/2 tiny", 80'(last_r[78:64] <= 15'd16330), 80'd1);

        do_op("0.25", 80'h3FFD_8000_0000_0000_0000, 0);
        do_op("zero", 80'h0000_0000_0000_0000_0000, 0);
        do_op("-zero", 80'h8000_0000_0000_0000_0000, 0);
        do_op("denormal", 80'h0000_0000_0000_0000_0001, 0);
        do_op("0.5", 80'h3FFE_8000_0000_0000_0000, 0);
        do_op("+inf", 80'h7FFF_8000_0000_0000_0000, 0);
        do_op("nan", 80'hFFFF_C000_0000_0000_0001, 0);
        do_op("unnormal", 80'h4000_4000_0000_0000_0000, 0);
        do_op("2^63", 80'h403E_8000_0000_0000_0000, 0);
        do_op("maxreduce", 80'h403D_FFFF_FFFF_FFFF_FFFF, 0);
        do_op("-3.0", 80'hC000_C000_0000_0000_0000, 0);
        do_op("-2^62", 80'hC03D_8000_0000_0000_0000, 0);

        for (int i = 0; i < 12; i++) begin
            rnd = {$urandom, $urandom};
            x = {1'($urandom), 15'(16382 + $urandom_range(0, 64)), 1'b1, rnd[62:0]};
            do_op($sformatf("rand%0d", i), x, 0);
        end

        do_op("3.0 glitch", 80'h4000_C000_0000_0000_0000, 10);

        // Abort a reduction with reset partway through DIVIDE.
        @(negedge clk);
        operand_in = 80'h4000_C000_0000_0000_0000;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort no done", 80'(seen), 80'd0);
        chk_reset_outputs("abort");
        @(posedge clk);
        #1;
        chk_reset_outputs("abort held");
        @(negedge clk);
        reset_n = 1'b1;
        do_op("3.0 post-rst", 80'h4000_C000_0000_0000_0000, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
